fifo_cu_mc: RTL and testbench

Parametrised multi-channel synchronous FIFO control unit, successor to the two-FSM read/write control path. It manages CH independent FIFOs that share one clock and one banked storage RAM. For each channel it gates write and read requests into RAM enables, and it owns the pointers, occupancy count, full/empty/almost flags, error flags and a per-channel flush. The datapath RAM sits outside this block and is driven by its enables and addresses.

---
 rtl/fifo_cu_pkg.sv | 23 ++
 rtl/fifo_cu_chan.sv | 128 ++++++++++++
 rtl/fifo_cu_mc.sv | 68 ++++++
 tb/tb_fifo_cu_mc.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_cu_pkg.sv
// Shared definitions for the multi-channel FIFO control unit.
//   - cu_state_t : per-channel occupancy state
//   - addr_w()   : pointer width for a given channel depth
//   - FLG_*      : bit positions in the packed status-flag vector
package fifo_cu_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } cu_state_t;

  function automatic int addr_w(input int depth);
    return $clog2(depth);
  endfunction

  localparam int FLG_FULL   = 0;
  localparam int FLG_EMPTY  = 1;
  localparam int FLG_AFULL  = 2;
  localparam int FLG_AEMPTY = 3;
  localparam int FLG_NUM    = 4;

endpackage

// File: rtl/fifo_cu_chan.sv
// One FIFO channel control path: request gating, read/write pointers,
// occupancy count, registered status flags, occupancy FSM and error flags.
// Optional macro FIFO_CU_ERR_STICKY_EN: error flags hold until err_clr;
// without it they are single-cycle pulses and err_clr is ignored.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   wt_req, rd_req           push / pop request
//   flush, err_clr           synchronous flush, error clear
//   wt_en, rd_en             accepted push / pop (combinational)
//   wt_addr, rd_addr         registered pointers
//   count                    registered occupancy 0..DEPTH
//   full/empty/almost_*      registered flags, aligned with count
//   push_err, pop_err        rejected-request flags
module fifo_cu_chan
  import fifo_cu_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  localparam int AW = addr_w(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wt_req,
  input  logic          rd_req,
  input  logic          flush,
  input  logic          err_clr,
  output logic          wt_en,
  output logic          rd_en,
  output logic [AW-1:0] wt_addr,
  output logic [AW-1:0] rd_addr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          push_err,
  output logic          pop_err
);

  cu_state_t          state;
  logic [CW-1:0]      cnt_nxt;
  logic [FLG_NUM-1:0] flg_nxt;
  logic [FLG_NUM-1:0] flg_zero;
  logic               push_err_new;
  logic               pop_err_new;

  function automatic logic [FLG_NUM-1:0] decode(input logic [CW-1:0] c);
    logic [FLG_NUM-1:0] f;
    f             = '0;
    f[FLG_FULL]   = (c == CW'(DEPTH));
    f[FLG_EMPTY]  = (c == '0);
    f[FLG_AFULL]  = (c >= CW'(DEPTH - AF_MARGIN));
    f[FLG_AEMPTY] = (c <= CW'(AE_MARGIN));
    return f;
  endfunction

  // A full channel still takes a push when a pop frees a slot in the same
  // cycle; full implies non-empty, so that pop is always accepted too.
  assign rd_en = rd_req & ~empty & ~flush & ~rst;
  assign wt_en = wt_req & ~flush & (~full | rd_req) & ~rst;

  // Flags are decoded from the next count so they line up with count.
  assign cnt_nxt  = count + CW'(wt_en) - CW'(rd_en);
  assign flg_nxt  = decode(cnt_nxt);
  assign flg_zero = decode('0);

  assign push_err_new = wt_req & full & ~rd_req & ~flush;
  assign pop_err_new  = rd_req & empty & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wt_addr      <= '0;
      rd_addr      <= '0;
      count        <= '0;
      full         <= flg_zero[FLG_FULL];
      empty        <= flg_zero[FLG_EMPTY];
      almost_full  <= flg_zero[FLG_AFULL];
      almost_empty <= flg_zero[FLG_AEMPTY];
      state        <= ST_EMPTY;
    end else begin
      wt_addr      <= wt_addr + AW'(wt_en);
      rd_addr      <= rd_addr + AW'(rd_en);
      count        <= cnt_nxt;
      full         <= flg_nxt[FLG_FULL];
      empty        <= flg_nxt[FLG_EMPTY];
      almost_full  <= flg_nxt[FLG_AFULL];
      almost_empty <= flg_nxt[FLG_AEMPTY];
      case (state)
        ST_EMPTY:   if (wt_en) state <= ST_PARTIAL;
        ST_PARTIAL: begin
          if (cnt_nxt == CW'(DEPTH)) state <= ST_FULL;
          else if (cnt_nxt == '0)    state <= ST_EMPTY;
        end
        ST_FULL:    if (rd_en && !wt_en) state <= ST_PARTIAL;
        default:    state <= ST_EMPTY;
      endcase
    end
  end

`ifdef FIFO_CU_ERR_STICKY_EN
  // Clear wins over an error raised in the same cycle; flush leaves errors.
  always_ff @(posedge clk) begin
    if (rst || err_clr) begin
      push_err <= 1'b0;
      pop_err  <= 1'b0;
    end else begin
      push_err <= push_err | push_err_new;
      pop_err  <= pop_err | pop_err_new;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      push_err <= 1'b0;
      pop_err  <= 1'b0;
    end else begin
      push_err <= push_err_new;
      pop_err  <= pop_err_new;
    end
  end
`endif

endmodule

// File: rtl/fifo_cu_mc.sv
// Multi-channel synchronous FIFO control unit: CH independent channels that
// share one clock and a banked RAM addressed as {channel, pointer}.
// Optional macro FIFO_CU_ERR_STICKY_EN selects sticky error flags.
// Ports (per-channel vectors, channel i in bit i or slice i):
//   clk_cu, rst_in_cu                  clock, synchronous active-high reset
//   wt_req_cu, rd_req_cu               push / pop requests
//   flush_cu, err_clr_cu               per-channel flush and error clear
//   wt_en_cu, rd_en_cu                 RAM write / read enables
//   wt_addr_cu, rd_addr_cu             CH*AW registered pointers
//   count_cu                           CH*CW registered occupancy
//   full/empty/almost_full/almost_empty_cu  registered flags
//   push_on_full_error_cu, pop_on_empty_error_cu  rejected-request flags
module fifo_cu_mc
  import fifo_cu_pkg::*;
#(
  parameter int CH        = 2,
  parameter int DEPTH     = 16,
  parameter int AF_MARGIN = 2,
  parameter int AE_MARGIN = 2,
  localparam int AW = addr_w(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_cu,
  input  logic             rst_in_cu,
  input  logic [CH-1:0]    wt_req_cu,
  input  logic [CH-1:0]    rd_req_cu,
  input  logic [CH-1:0]    flush_cu,
  input  logic [CH-1:0]    err_clr_cu,
  output logic [CH-1:0]    wt_en_cu,
  output logic [CH-1:0]    rd_en_cu,
  output logic [CH*AW-1:0] wt_addr_cu,
  output logic [CH*AW-1:0] rd_addr_cu,
  output logic [CH*CW-1:0] count_cu,
  output logic [CH-1:0]    full_cu,
  output logic [CH-1:0]    empty_cu,
  output logic [CH-1:0]    almost_full_cu,
  output logic [CH-1:0]    almost_empty_cu,
  output logic [CH-1:0]    push_on_full_error_cu,
  output logic [CH-1:0]    pop_on_empty_error_cu
);

  for (genvar i = 0; i < CH; i++) begin : g_ch
    fifo_cu_chan #(
      .DEPTH    (DEPTH),
      .AF_MARGIN(AF_MARGIN),
      .AE_MARGIN(AE_MARGIN)
    ) u_chan (
      .clk         (clk_cu),
      .rst         (rst_in_cu),
      .wt_req      (wt_req_cu[i]),
      .rd_req      (rd_req_cu[i]),
      .flush       (flush_cu[i]),
      .err_clr     (err_clr_cu[i]),
      .wt_en       (wt_en_cu[i]),
      .rd_en       (rd_en_cu[i]),
      .wt_addr     (wt_addr_cu[i*AW +: AW]),
      .rd_addr     (rd_addr_cu[i*AW +: AW]),
      .count       (count_cu[i*CW +: CW]),
      .full        (full_cu[i]),
      .empty       (empty_cu[i]),
      .almost_full (almost_full_cu[i]),
      .almost_empty(almost_empty_cu[i]),
      .push_err    (push_on_full_error_cu[i]),
      .pop_err     (pop_on_empty_error_cu[i])
    );
  end

endmodule

// File: tb/tb_fifo_cu_mc.sv
module tb_fifo_cu_mc;
  localparam int CH = 2, DEPTH = 8, AF = 2, AE = 2, AW = 3, CW = 4;

  logic             clk_cu = 1'b0;
  logic             rst_in_cu;
  logic [CH-1:0]    wt_req_cu, rd_req_cu, flush_cu, err_clr_cu;
  logic [CH-1:0]    wt_en_cu, rd_en_cu;
  logic [CH*AW-1:0] wt_addr_cu, rd_addr_cu;
  logic [CH*CW-1:0] count_cu;
  logic [CH-1:0]    full_cu, empty_cu, almost_full_cu, almost_empty_cu;
  logic [CH-1:0]    push_on_full_error_cu, pop_on_empty_error_cu;

  int total = 0;
  int bad   = 0;

  // Reference model: occupancy as a token queue, pointers as integers mod DEPTH.
  int m_q[CH][$];
  int m_wp[CH];
  int m_rp[CH];
  bit m_perr[CH];
  bit m_eerr[CH];
  int tok = 0;

  fifo_cu_mc #(.CH(CH), .DEPTH(DEPTH), .AF_MARGIN(AF), .AE_MARGIN(AE)) dut (
    .clk_cu(clk_cu), .rst_in_cu(rst_in_cu),
    .wt_req_cu(wt_req_cu), .rd_req_cu(rd_req_cu),
    .flush_cu(flush_cu), .err_clr_cu(err_clr_cu),
    .wt_en_cu(wt_en_cu), .rd_en_cu(rd_en_cu),
    .wt_addr_cu(wt_addr_cu), .rd_addr_cu(rd_addr_cu), .count_cu(count_cu),
    .full_cu(full_cu), .empty_cu(empty_cu),
    .almost_full_cu(almost_full_cu), .almost_empty_cu(almost_empty_cu),
    .push_on_full_error_cu(push_on_full_error_cu),
    .pop_on_empty_error_cu(pop_on_empty_error_cu)
  );

  always #5 clk_cu = ~clk_cu;

  function automatic int occ(int c);
    return m_q[c].size();
  endfunction

  function automatic bit exp_wen(int c);
    return !rst_in_cu && wt_req_cu[c] && !flush_cu[c] && (occ(c) < DEPTH || rd_req_cu[c]);
  endfunction

  function automatic bit exp_ren(int c);
    return !rst_in_cu && rd_req_cu[c] && !flush_cu[c] && occ(c) > 0;
  endfunction

  function automatic int cnt_of(int c);
    return int'(count_cu[c*CW +: CW]);
  endfunction

  function automatic int wa_of(int c);
    return int'(wt_addr_cu[c*AW +: AW]);
  endfunction

  function automatic int ra_of(int c);
    return int'(rd_addr_cu[c*AW +: AW]);
  endfunction

  task automatic drive(input logic rst, input logic [CH-1:0] w, r, f, e);
    rst_in_cu = rst; wt_req_cu = w; rd_req_cu = r; flush_cu = f; err_clr_cu = e;
    #1;
  endtask

  // Advance one clock edge and move the model along with it.
  task automatic tick();
    bit we[CH], re[CH], pe[CH], ee[CH];
    for (int c = 0; c < CH; c++) begin
      we[c] = exp_wen(c);
      re[c] = exp_ren(c);
      pe[c] = wt_req_cu[c] && occ(c) == DEPTH && !rd_req_cu[c] && !flush_cu[c];
      ee[c] = rd_req_cu[c] && occ(c) == 0 && !flush_cu[c];
    end
    @(posedge clk_cu);
    for (int c = 0; c < CH; c++) begin
      if (rst_in_cu) begin
        m_q[c].delete(); m_wp[c] = 0; m_rp[c] = 0; m_perr[c] = 0; m_eerr[c] = 0;
      end else begin
`ifdef FIFO_CU_ERR_STICKY_EN
        m_perr[c] = err_clr_cu[c] ? 1'b0 : (m_perr[c] | pe[c]);
        m_eerr[c] = err_clr_cu[c] ? 1'b0 : (m_eerr[c] | ee[c]);
`else
        m_perr[c] = pe[c];
        m_eerr[c] = ee[c];
`endif
        if (flush_cu[c]) begin
          m_q[c].delete(); m_wp[c] = 0; m_rp[c] = 0;
        end else begin
          if (re[c]) void'(m_q[c].pop_front());
          if (we[c]) begin m_q[c].push_back(tok); tok++; end
          m_wp[c] = (m_wp[c] + int'(we[c])) % DEPTH;
          m_rp[c] = (m_rp[c] + int'(re[c])) % DEPTH;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    total++; if (wt_en_cu !== 2'b00) begin bad++; $display("FAIL reset_wt_en got %b expected 00", wt_en_cu); end
    tick();
    drive(1'b1, 2'b11, 2'b00, 2'b00, 2'b00);
    total++; if (wt_en_cu !== 2'b00) begin bad++; $display("FAIL reset_wt_en2 got %b expected 00", wt_en_cu); end
    tick();
    total++; if (empty_cu !== 2'b11) begin bad++; $display("FAIL reset_empty got %b expected 11", empty_cu); end
    total++; if (almost_empty_cu !== 2'b11) begin bad++; $display("FAIL reset_aempty got %b expected 11", almost_empty_cu); end
    total++; if (full_cu !== 2'b00 || almost_full_cu !== 2'b00) begin bad++; $display("FAIL reset_full got %b/%b expected 00/00", full_cu, almost_full_cu); end
    total++; if (count_cu !== '0) begin bad++; $display("FAIL reset_count got %h expected 0", count_cu); end
    total++; if (wt_addr_cu !== '0 || rd_addr_cu !== '0) begin bad++; $display("FAIL reset_addr got %h/%h expected 0/0", wt_addr_cu, rd_addr_cu); end
    total++; if (push_on_full_error_cu !== '0 || pop_on_empty_error_cu !== '0) begin bad++; $display("FAIL reset_err got %b/%b expected 00/00", push_on_full_error_cu, pop_on_empty_error_cu); end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  task automatic test_fill();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
      total++; if (wt_en_cu !== 2'b01) begin bad++; $display("FAIL fill_wt_en i=%0d got %b expected 01", i, wt_en_cu); end
      tick();
      total++; if (cnt_of(0) != i + 1) begin bad++; $display("FAIL fill_count got %0d expected %0d", cnt_of(0), i + 1); end
      total++; if (almost_full_cu[0] !== (i + 1 >= 6)) begin bad++; $display("FAIL fill_afull cnt=%0d got %b expected %b", i + 1, almost_full_cu[0], (i + 1 >= 6)); end
      total++; if (full_cu[0] !== (i + 1 == 8)) begin bad++; $display("FAIL fill_full cnt=%0d got %b expected %b", i + 1, full_cu[0], (i + 1 == 8)); end
      total++; if (empty_cu[1] !== 1'b1 || almost_empty_cu[1] !== 1'b1 || cnt_of(1) != 0) begin bad++; $display("FAIL fill_ch1 got empty=%b count=%0d expected 1/0", empty_cu[1], cnt_of(1)); end
    end
    drive(1'b0, 2'b01, 2'b00, 2'b00, 2'b00);
    total++; if (wt_en_cu[0] !== 1'b0) begin bad++; $display("FAIL overflow_wt_en got %b expected 0", wt_en_cu[0]); end
    tick();
    total++; if (push_on_full_error_cu[0] !== 1'b1) begin bad++; $display("FAIL overflow_err got %b expected 1", push_on_full_error_cu[0]); end
    total++; if (cnt_of(0) != 8 || push_on_full_error_cu[1] !== 1'b0) begin bad++; $display("FAIL overflow_count got %0d expected 8", cnt_of(0)); end
    // Clear/settle the error so the following tests start clean in either mode.
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b11);
    tick();
  endtask

  task automatic test_full_pushpop();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 2'b01, 2'b01, 2'b00, 2'b00);
      total++; if (wt_en_cu[0] !== 1'b1 || rd_en_cu[0] !== 1'b1) begin bad++; $display("FAIL fullpp_en got %b/%b expected 1/1", wt_en_cu[0], rd_en_cu[0]); end
      tick();
      total++; if (cnt_of(0) != 8 || full_cu[0] !== 1'b1) begin bad++; $display("FAIL fullpp_count got %0d full=%b expected 8/1", cnt_of(0), full_cu[0]); end
      total++; if (wa_of(0) != (i + 1) % 8 || ra_of(0) != (i + 1) % 8) begin bad++; $display("FAIL fullpp_ptr got %0d/%0d expected %0d", wa_of(0), ra_of(0), (i + 1) % 8); end
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 2'b00, 2'b01, 2'b00, 2'b00);
      total++; if (rd_en_cu[0] !== 1'b1) begin bad++; $display("FAIL drain_rd_en got %b expected 1", rd_en_cu[0]); end
      tick();
      total++; if (cnt_of(0) != 7 - i || empty_cu[0] !== (i == 7) || almost_empty_cu[0] !== (7 - i <= 2)) begin
        bad++; $display("FAIL drain_state got count=%0d empty=%b ae=%b expected %0d", cnt_of(0), empty_cu[0], almost_empty_cu[0], 7 - i);
      end
    end
    drive(1'b0, 2'b00, 2'b01, 2'b00, 2'b00);
    total++; if (rd_en_cu[0] !== 1'b0) begin bad++; $display("FAIL underflow_rd_en got %b expected 0", rd_en_cu[0]); end
    tick();
    total++; if (pop_on_empty_error_cu[0] !== 1'b1 || cnt_of(0) != 0) begin bad++; $display("FAIL underflow_err got %b count=%0d expected 1/0", pop_on_empty_error_cu[0], cnt_of(0)); end
    drive(1'b0, 2'b01, 2'b01, 2'b00, 2'b01);
    total++; if (rd_en_cu[0] !== 1'b0 || wt_en_cu[0] !== 1'b1) begin bad++; $display("FAIL emptypp_en got %b/%b expected 1/0", wt_en_cu[0], rd_en_cu[0]); end
    tick();
    total++; if (cnt_of(0) != 1 || empty_cu[0] !== 1'b0) begin bad++; $display("FAIL emptypp_count got %0d expected 1", cnt_of(0)); end
  endtask

  task automatic test_flush();
    int wa0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b0, 2'b10, 2'b00, 2'b00, 2'b00);
      tick();
    end
    total++; if (cnt_of(1) != 5) begin bad++; $display("FAIL flush_pre got %0d expected 5", cnt_of(1)); end
    wa0 = wa_of(0);
    drive(1'b0, 2'b10, 2'b00, 2'b10, 2'b00);
    total++; if (wt_en_cu[1] !== 1'b0) begin bad++; $display("FAIL flush_wt_en got %b expected 0", wt_en_cu[1]); end
    tick();
    total++; if (cnt_of(1) != 0 || empty_cu[1] !== 1'b1 || wa_of(1) != 0 || ra_of(1) != 0) begin
      bad++; $display("FAIL flush_ch1 got count=%0d empty=%b ptr=%0d/%0d expected 0/1/0/0", cnt_of(1), empty_cu[1], wa_of(1), ra_of(1));
    end
    total++; if (cnt_of(0) != 1 || wa_of(0) != wa0) begin bad++; $display("FAIL flush_ch0 got count=%0d wa=%0d expected 1/%0d", cnt_of(0), wa_of(0), wa0); end
  endtask

  task automatic test_errors();
    drive(1'b0, 2'b00, 2'b10, 2'b00, 2'b00);
    tick();
    total++; if (pop_on_empty_error_cu[1] !== 1'b1) begin bad++; $display("FAIL err_raise got %b expected 1", pop_on_empty_error_cu[1]); end
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
      tick();
`ifdef FIFO_CU_ERR_STICKY_EN
      total++; if (pop_on_empty_error_cu[1] !== 1'b1) begin bad++; $display("FAIL err_hold i=%0d got %b expected 1", i, pop_on_empty_error_cu[1]); end
`else
      total++; if (pop_on_empty_error_cu[1] !== 1'b0) begin bad++; $display("FAIL err_pulse i=%0d got %b expected 0", i, pop_on_empty_error_cu[1]); end
`endif
    end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b10);
    tick();
    total++; if (pop_on_empty_error_cu[1] !== 1'b0) begin bad++; $display("FAIL err_clr got %b expected 0", pop_on_empty_error_cu[1]); end
    drive(1'b0, 2'b00, 2'b10, 2'b00, 2'b10);
    tick();
`ifdef FIFO_CU_ERR_STICKY_EN
    total++; if (pop_on_empty_error_cu[1] !== 1'b0) begin bad++; $display("FAIL err_clr_prio got %b expected 0", pop_on_empty_error_cu[1]); end
`else
    total++; if (pop_on_empty_error_cu[1] !== 1'b1) begin bad++; $display("FAIL err_clr_ignored got %b expected 1", pop_on_empty_error_cu[1]); end
`endif
  endtask

  task automatic test_random();
    logic r;
    logic [CH-1:0] w, rd, f, e;
    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 63) == 0);
      w  = CH'($urandom);
      rd = CH'($urandom);
      f  = '0; e = '0;
      for (int c = 0; c < CH; c++) begin
        f[c] = ($urandom_range(0, 19) == 0);
        e[c] = ($urandom_range(0, 9) == 0);
      end
      // Bias toward filling or draining in phases to reach both boundaries.
      if ((n / 60) % 2 == 0) w = w | CH'($urandom); else rd = rd | CH'($urandom);
      drive(r, w, rd, f, e);
      for (int c = 0; c < CH; c++) begin
        total++; if (wt_en_cu[c] !== exp_wen(c) || rd_en_cu[c] !== exp_ren(c)) begin
          bad++; $display("FAIL rnd_en n=%0d ch%0d got %b/%b expected %b/%b", n, c, wt_en_cu[c], rd_en_cu[c], exp_wen(c), exp_ren(c));
        end
      end
      tick();
      for (int c = 0; c < CH; c++) begin
        total++; if (cnt_of(c) != occ(c) || wa_of(c) != m_wp[c] || ra_of(c) != m_rp[c]) begin
          bad++; $display("FAIL rnd_cnt n=%0d ch%0d got %0d/%0d/%0d expected %0d/%0d/%0d", n, c, cnt_of(c), wa_of(c), ra_of(c), occ(c), m_wp[c], m_rp[c]);
        end
        total++; if (full_cu[c] !== (occ(c) == DEPTH) || empty_cu[c] !== (occ(c) == 0) ||
                     almost_full_cu[c] !== (occ(c) >= DEPTH - AF) || almost_empty_cu[c] !== (occ(c) <= AE)) begin
          bad++; $display("FAIL rnd_flags n=%0d ch%0d got f=%b e=%b af=%b ae=%b for occupancy %0d", n, c, full_cu[c], empty_cu[c], almost_full_cu[c], almost_empty_cu[c], occ(c));
        end
        total++; if (push_on_full_error_cu[c] !== m_perr[c] || pop_on_empty_error_cu[c] !== m_eerr[c]) begin
          bad++; $display("FAIL rnd_err n=%0d ch%0d got %b/%b expected %b/%b", n, c, push_on_full_error_cu[c], pop_on_empty_error_cu[c], m_perr[c], m_eerr[c]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 2'b11, 2'b00, 2'b00, 2'b00);
      tick();
    end
    drive(1'b1, 2'b11, 2'b11, 2'b00, 2'b00);
    tick();
    total++; if (count_cu !== '0 || empty_cu !== 2'b11 || wt_addr_cu !== '0 || rd_addr_cu !== '0) begin
      bad++; $display("FAIL midreset got count=%h empty=%b expected 0/11", count_cu, empty_cu);
    end
    drive(1'b0, 2'b00, 2'b00, 2'b00, 2'b00);
  endtask

  initial begin
    drive(1'b1, 2'b00, 2'b00, 2'b00, 2'b00);
    test_reset();
    test_fill();
    test_full_pushpop();
    test_drain();
    test_flush();
    test_errors();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
